vending_machine: RTL and testbench

//   Coin-accumulating vending controller for a single product.
//   - Accepts one coin per clock: nickel (5) or dime (10).
//   - Once the accumulated credit reaches PRICE, pulses `dispense` for one cycle.
//   - Leaf block: the coin-acceptor front end drives it; `dispense` goes to the product-release actuator.

---
 rtl/vending_machine.sv | 74 +++++++
 tb/tb_vending_machine.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// vending_machine: coin-accumulating vending controller for a single product.
//   Each rising edge adds the value of the sampled coin to the running credit.
//   When the credit reaches PRICE, a one-cycle dispense pulse is issued.
//   Optional feature macro: OVERPAY_CREDIT_EN. When it is defined, credit above
//   PRICE carries into the next purchase. When it is undefined, that excess is
//   discarded.
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-low reset (0 = reset)
//   coin      in   2  00 none, 01 nickel, 10 dime, 11 invalid (treated as none)
//   dispense  out  1  registered one-cycle product-release pulse
module vending_machine #(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned NICKEL_V = 5,
  parameter int unsigned DIME_V   = 10,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       dispense
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_NICKEL = 2'b01,
    COIN_DIME   = 2'b10,
    COIN_BAD    = 2'b11
  } coin_e;

  logic [CREDIT_W-1:0] credit;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;
  logic                buy_c;
  logic [CREDIT_W-1:0] credit_after_buy;

  // Value of this cycle's coin; an invalid code is worth nothing.
  always_comb begin
    coin_val = '0;
    case (coin_e'(coin))
      COIN_NICKEL: coin_val = SUM_W'(NICKEL_V);
      COIN_DIME:   coin_val = SUM_W'(DIME_V);
      default:     coin_val = '0;
    endcase
  end

  // The sum has one extra bit, so the credit plus a dime cannot wrap.
  always_comb begin
    sum   = {1'b0, credit} + coin_val;
    buy_c = (sum >= SUM_W'(PRICE));
`ifdef OVERPAY_CREDIT_EN
    credit_after_buy = CREDIT_W'(sum - SUM_W'(PRICE));
`else
    credit_after_buy = '0;
`endif
  end

  // Credit accumulator and registered dispense pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit   <= '0;
      dispense <= 1'b0;
    end else if (buy_c) begin
      credit   <= credit_after_buy;
      dispense <= 1'b1;
    end else begin
      credit   <= CREDIT_W'(sum);
      dispense <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: scoreboard bench for vending_machine.
//   The stimulus process drives reset and coin on the falling edge. It keeps a
//   behavioural credit model and queues the dispense value expected after the
//   next rising edge. A separate monitor pops one entry per cycle and compares.
module tb_vending_machine;

  localparam int PRICE = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       dispense;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int model_credit = 0;

  vending_machine dut (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin),
    .dispense (dispense)
  );

  always #5 clk = ~clk;

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 0;
    endcase
  endfunction

  // Apply one cycle of stimulus and queue the expected dispense for that edge.
  task automatic drive(input logic rst_v, input logic [1:0] c);
    int total;
    bit exp;
    @(negedge clk);
    reset = rst_v;
    coin  = c;
    if (!rst_v) begin
      model_credit = 0;
      exp = 1'b0;
    end else begin
      total = model_credit + coin_value(c);
      if (total >= PRICE) begin
        exp = 1'b1;
`ifdef OVERPAY_CREDIT_EN
        model_credit = total - PRICE;
`else
        model_credit = 0;
`endif
      end else begin
        exp = 1'b0;
        model_credit = total;
      end
    end
    exp_q.push_back(exp);
  endtask

  task automatic coin_then_idle(input logic [1:0] c);
    drive(1'b1, c);
    drive(1'b1, 2'b00);
  endtask

  // Monitor: compare dispense after each rising edge against the queued value.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      bit exp;
      exp = exp_q.pop_front();
      checks++;
      if (dispense !== exp) begin
        errors++;
        $display("FAIL dispense @%0t: got %b expected %b", $time, dispense, exp);
      end
    end
  end

  initial begin
    // Reset, then stay idle.
    drive(1'b0, 2'b10);
    repeat (5) drive(1'b1, 2'b00);
    // Three nickels.
    repeat (3) coin_then_idle(2'b01);
    // Dime then nickel, followed by nickel then dime.
    coin_then_idle(2'b10); coin_then_idle(2'b01);
    coin_then_idle(2'b01); coin_then_idle(2'b10);
    // Two dimes, then a single nickel.
    coin_then_idle(2'b10); coin_then_idle(2'b10);
    coin_then_idle(2'b01);
    drive(1'b0, 2'b00);
    // Nickel, invalid code, dime.
    coin_then_idle(2'b01); coin_then_idle(2'b11); coin_then_idle(2'b10);
    // Reset while credit is partial; the dime in the reset cycle is ignored.
    coin_then_idle(2'b10);
    drive(1'b0, 2'b10);
    coin_then_idle(2'b01);
    coin_then_idle(2'b10);
    // Coins held across cycles, back to back.
    repeat (6) drive(1'b1, 2'b10);
    repeat (5) drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    // Random coins with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] c;
      logic r;
      c = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 29) != 0);
      drive(r, c);
    end
    drive(1'b1, 2'b00);
    // Wait for the monitor to drain the queue, with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
